// File: rtl/bayer_remosaic.sv
// Camera emulator: turns a half-resolution RGB stream into a full-resolution 12-bit Bayer raw stream.
// Each RGB pixel becomes one 2x2 quad; the {B,G} half is line-buffered and replayed on the odd row.
module bayer_remosaic #(
  parameter int IMG_W  = 1280,
  parameter int IMG_H  = 960,
  parameter int HBLANK = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iRed,
  input  logic [11:0] iGreen,
  input  logic [11:0] iBlue,
  input  logic        iDVAL,
  output logic        oREADY,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic        oEOF
);

  localparam int          HALF_W     = IMG_W / 2;
  localparam int          AW         = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [9:0]  LAST_C     = 10'(HALF_W - 1);
  localparam logic [10:0] LAST_Y     = 11'(IMG_H - 2);
  localparam logic [15:0] BLANK_LAST = 16'(HBLANK - 1);

  typedef enum logic [2:0] {
    EVEN_A  = 3'd0,
    EVEN_B  = 3'd1,
    BLANK_E = 3'd2,
    ODD_A   = 3'd3,
    ODD_B   = 3'd4,
    BLANK_O = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [10:0] y_r, y_s;
  logic [9:0]  c_r, c_s, c_inc_s;
  logic [15:0] blank_r, blank_s;
  logic [11:0] red_r, red_s;
  logic [11:0] data_r, data_s;
  logic [10:0] x_r, x_s, yo_r, yo_s;
  logic        dval_r, dval_s, eof_r, eof_s;
  logic        wr_en_s, rd_en_s;
  logic [AW-1:0] rd_addr_s;
  logic [23:0] rd_data_r;
  logic [23:0] line_mem [0:HALF_W-1];

  assign c_inc_s = c_r + 10'd1;

  // Next-state, counter and output-sample selection for the raster sequencer.
  always_comb begin
    state_s   = state_r;
    y_s       = y_r;
    c_s       = c_r;
    blank_s   = blank_r;
    red_s     = red_r;
    data_s    = data_r;
    x_s       = x_r;
    yo_s      = yo_r;
    dval_s    = 1'b0;
    eof_s     = 1'b0;
    wr_en_s   = 1'b0;
    rd_en_s   = 1'b0;
    rd_addr_s = c_r[AW-1:0];
    case (state_r)
      EVEN_A: begin
        if (iDVAL) begin
          data_s  = iGreen;
          x_s     = {c_r, 1'b0};
          yo_s    = y_r;
          dval_s  = 1'b1;
          wr_en_s = 1'b1;
          red_s   = iRed;
          state_s = EVEN_B;
        end else begin
          state_s = EVEN_A;
        end
      end
      EVEN_B: begin
        data_s  = red_r;
        x_s     = {c_r, 1'b1};
        yo_s    = y_r;
        dval_s  = 1'b1;
        blank_s = 16'd0;
        if (c_r == LAST_C) begin
          c_s     = 10'd0;
          state_s = BLANK_E;
        end else begin
          c_s     = c_inc_s;
          state_s = EVEN_A;
        end
      end
      BLANK_E: begin
        if (blank_r == BLANK_LAST) begin
          // Prefetch column 0 so ODD_A has its B sample ready.
          rd_en_s   = 1'b1;
          rd_addr_s = {AW{1'b0}};
          blank_s   = 16'd0;
          state_s   = ODD_A;
        end else begin
          blank_s = blank_r + 16'd1;
        end
      end
      ODD_A: begin
        data_s  = rd_data_r[23:12];
        x_s     = {c_r, 1'b0};
        yo_s    = y_r + 11'd1;
        dval_s  = 1'b1;
        state_s = ODD_B;
      end
      ODD_B: begin
        data_s = rd_data_r[11:0];
        x_s    = {c_r, 1'b1};
        yo_s   = y_r + 11'd1;
        dval_s = 1'b1;
        if (c_r == LAST_C) begin
          c_s     = 10'd0;
          eof_s   = (y_r == LAST_Y);
          blank_s = 16'd0;
          state_s = BLANK_O;
        end else begin
          rd_en_s   = 1'b1;
          rd_addr_s = c_inc_s[AW-1:0];
          c_s       = c_inc_s;
          state_s   = ODD_A;
        end
      end
      BLANK_O: begin
        if (blank_r == BLANK_LAST) begin
          blank_s = 16'd0;
          y_s     = (y_r == LAST_Y) ? 11'd0 : (y_r + 11'd2);
          state_s = EVEN_A;
        end else begin
          blank_s = blank_r + 16'd1;
        end
      end
      default: begin
        state_s = EVEN_A;
      end
    endcase
  end

  // Sequencer state and registered output samples.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_r <= EVEN_A;
      y_r     <= 11'd0;
      c_r     <= 10'd0;
      blank_r <= 16'd0;
      red_r   <= 12'd0;
      data_r  <= 12'd0;
      x_r     <= 11'd0;
      yo_r    <= 11'd0;
      dval_r  <= 1'b0;
      eof_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      y_r     <= y_s;
      c_r     <= c_s;
      blank_r <= blank_s;
      red_r   <= red_s;
      data_r  <= data_s;
      x_r     <= x_s;
      yo_r    <= yo_s;
      dval_r  <= dval_s;
      eof_r   <= eof_s;
    end
  end

  // {B,G} line buffer: written on the even row, read one cycle ahead on the odd row.
  always_ff @(posedge iCLK) begin
    if (wr_en_s) begin
      line_mem[c_r[AW-1:0]] <= {iBlue, iGreen};
    end
    if (rd_en_s) begin
      rd_data_r <= line_mem[rd_addr_s];
    end
  end

  assign oREADY  = (state_r == EVEN_A);
  assign oDATA   = data_r;
  assign oDVAL   = dval_r;
  assign oX_Cont = x_r;
  assign oY_Cont = yo_r;
  assign oEOF    = eof_r;

endmodule

// File: tb/tb_bayer_remosaic.sv
// Self-checking bench for bayer_remosaic: a timed expected-sample stream built per accepted RGB pixel,
// checked every cycle, plus a raster-based round-trip check of every quad at each end of frame.
module tb_bayer_remosaic;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] r_in, g_in, b_in;
  logic        dval_in;
  logic        ready;
  logic [11:0] data;
  logic        dval;
  logic [10:0] x_cont, y_cont;
  logic        eof;

  bayer_remosaic #(.IMG_W(W), .IMG_H(H), .HBLANK(HB)) dut (
    .iCLK(clk), .iRST(rst), .iRed(r_in), .iGreen(g_in), .iBlue(b_in), .iDVAL(dval_in),
    .oREADY(ready), .oDATA(data), .oDVAL(dval), .oX_Cont(x_cont), .oY_Cont(y_cont), .oEOF(eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int x;
    int y;
    int eof;
    int t;
  } ev_t;

  ev_t q[$];
  ev_t last;
  int  e, next_ok, mc, my;
  int  vecs = 0, fails = 0;
  int  eof_cnt = 0, eof_exp_cnt = 0, frames_m = 0;
  int  fr_r[H/2][W/2];
  int  fr_g[H/2][W/2];
  int  fr_b[H/2][W/2];
  int  raw[H][W];

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", nm, e, act, exp);
    end
  endtask

  task automatic push(input int d, input int x, input int y, input int ef, input int t);
    ev_t ev;
    ev.d = d; ev.x = x; ev.y = y; ev.eof = ef; ev.t = t;
    q.push_back(ev);
  endtask

  // Pixel accepted at edge k: its quad's even half appears at once, the odd row after the row ends.
  task automatic model_accept(input int k, input int r, input int g, input int b);
    fr_r[my/2][mc] = r;
    fr_g[my/2][mc] = g;
    fr_b[my/2][mc] = b;
    push(g, 2*mc, my, 0, k);
    push(r, 2*mc + 1, my, 0, k + 1);
    if (mc == W/2 - 1) begin
      for (int i = 0; i < W/2; i++) begin
        push(fr_b[my/2][i], 2*i, my + 1, 0, k + 2 + HB + 2*i);
        push(fr_g[my/2][i], 2*i + 1, my + 1, (my == H-2 && i == W/2-1) ? 1 : 0, k + 3 + HB + 2*i);
      end
      next_ok = k + 2 + 2*HB + W;
      mc = 0;
      if (my == H - 2) begin
        my = 0;
        frames_m++;
      end else begin
        my += 2;
      end
    end else begin
      mc++;
      next_ok = k + 2;
    end
  endtask

  task automatic round_trip();
    for (int yy = 0; yy < H/2; yy++) begin
      for (int cc = 0; cc < W/2; cc++) begin
        chk("rt_red",   raw[2*yy][2*cc+1],   fr_r[yy][cc]);
        chk("rt_green", raw[2*yy][2*cc],     fr_g[yy][cc]);
        chk("rt_green2", raw[2*yy+1][2*cc+1], fr_g[yy][cc]);
        chk("rt_blue",  raw[2*yy+1][2*cc],   fr_b[yy][cc]);
      end
    end
  endtask

  task automatic check();
    ev_t ev;
    int  exp_v;
    chk("ready", int'(ready), (e >= next_ok - 1) ? 1 : 0);
    exp_v = (q.size() > 0 && q[0].t == e) ? 1 : 0;
    chk("dval", int'(dval), exp_v);
    if (dval && eof) begin
      eof_cnt++;
      chk("eof_x", int'(x_cont), W - 1);
      chk("eof_y", int'(y_cont), H - 1);
    end
    if (exp_v == 1) begin
      ev = q.pop_front();
      chk("data", int'(data), ev.d);
      chk("x", int'(x_cont), ev.x);
      chk("y", int'(y_cont), ev.y);
      chk("eof", int'(eof), ev.eof);
      raw[ev.y][ev.x] = int'(data);
      last = ev;
      if (ev.eof == 1) begin
        eof_exp_cnt++;
        round_trip();
      end
    end else begin
      chk("hold_data", int'(data), last.d);
      chk("hold_x", int'(x_cont), last.x);
      chk("hold_y", int'(y_cont), last.y);
      chk("idle_eof", int'(eof), 0);
    end
  endtask

  task automatic step(input bit v, input int r, input int g, input int b);
    bit xfer;
    dval_in = v;
    r_in = 12'(r);
    g_in = 12'(g);
    b_in = 12'(b);
    xfer = v && (e >= next_ok - 1);
    @(posedge clk);
    e++;
    if (xfer) model_accept(e, r, g, b);
    @(negedge clk);
    check();
  endtask

  task automatic rand_step(input bit v);
    step(v, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dval_in = 1'b1;
    repeat (3) begin
      r_in = 12'($urandom);
      g_in = 12'($urandom);
      b_in = 12'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("rst_dval", int'(dval), 0);
      chk("rst_ready", int'(ready), 1);
      chk("rst_x", int'(x_cont), 0);
      chk("rst_y", int'(y_cont), 0);
      chk("rst_data", int'(data), 0);
      chk("rst_eof", int'(eof), 0);
    end
    q.delete();
    mc = 0;
    my = 0;
    e = 0;
    next_ok = 1;
    last.d = 0; last.x = 0; last.y = 0; last.eof = 0; last.t = 0;
    rst = 1'b0;
  endtask

  task automatic run_frames(input int target, input int mode);
    int guard = 0;
    int p = 0;
    while (frames_m < target && guard < 3000) begin
      case (mode)
        0: rand_step(1'b1);
        1: rand_step((p % 4 == 0) || (p % 4 == 3));
        default: rand_step(1'($urandom_range(0, 1)));
      endcase
      p++;
      guard++;
    end
    if (frames_m < target) begin
      fails++;
      $display("FAIL frame_timeout: got %0d frames, expected %0d", frames_m, target);
    end
  endtask

  initial begin
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++)
        raw[i][j] = 0;
    rst = 1'b1;
    dval_in = 1'b0;
    r_in = 12'd0; g_in = 12'd0; b_in = 12'd0;
    e = 0; next_ok = 1; mc = 0; my = 0;
    do_reset();

    // First transfer after reset, pinned with literal expectations.
    step(1'b1, 'h100, 'h200, 'h300);
    chk("first_g_data", int'(data), 'h200);
    chk("first_g_x", int'(x_cont), 0);
    chk("first_g_y", int'(y_cont), 0);
    rand_step(1'b1);
    chk("first_r_data", int'(data), 'h100);
    chk("first_r_x", int'(x_cont), 1);
    chk("first_r_ready", int'(ready), 1);

    run_frames(1, 0);
    run_frames(2, 1);
    run_frames(4, 2);
    repeat (13) rand_step(1'($urandom_range(0, 1)));
    do_reset();
    run_frames(5, 2);
    run_frames(6, 0);

    begin
      int guard = 0;
      while (q.size() > 0 && guard < 200) begin
        rand_step(1'b0);
        guard++;
      end
      if (q.size() > 0) begin
        fails++;
        $display("FAIL drain_timeout: %0d samples still pending, expected 0", q.size());
      end
    end
    repeat (4) rand_step(1'b0);
    chk("eof_count", eof_cnt, eof_exp_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
